fixed_point_tanh_core: RTL and testbench

- Evaluates tanh(x) for non-negative signed fixed-point inputs using an 8-segment piecewise-linear (chord) table.
- Sits between the absolute-value FIXED_POINT_CHANGE_SIGN stage (TARGET_SIGN=0) and the sign-restore FIXED_POINT_CHANGE_SIGN stage.
- Carries the original sign alongside the data, so its outputs wire directly into the restore stage's TARGET_SIGN, VALUE_IN and VALID_IN.
- Fully pipelined: one sample per cycle, no backpressure.

---
 rtl/cortez_tanh_pkg.sv | 55 +++++
 rtl/fixed_point_tanh_rom.sv | 29 ++
 rtl/fixed_point_tanh_core.sv | 152 +++++++++++++++
 tb/tb_fixed_point_tanh_core.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cortez_tanh_pkg.sv
// Shared constants, segment index type and elaboration-time table generators
// for the piecewise-linear tanh core (chord of tanh over 0.5-wide segments).
package cortez_tanh_pkg;

  localparam int NUM_SEGMENTS = 8;
  localparam int SEG_BITS     = $clog2(NUM_SEGMENTS);
  localparam int SEG_SHIFT    = 1;
  localparam int X_SAT_INT    = 4;

  typedef logic [SEG_BITS-1:0] seg_t;

  // Table values are derived in Q40 integer arithmetic so the generators stay
  // pure constant functions that every tool can evaluate during elaboration.
  localparam int              CALC_FRAC = 40;
  localparam int              EXP_TERMS = 60;
  localparam logic [127:0]    ONE_Q     = 128'd1 << CALC_FRAC;
  localparam logic [127:0]    HALF_Q    = 128'd1 << (CALC_FRAC - 1);

  // e^(2*i/2^SEG_SHIFT) in Q40 via its Taylor series.
  function automatic logic [127:0] exp_q(input int i);
    logic [127:0] term;
    logic [127:0] sum;
    term = ONE_Q;
    sum  = ONE_Q;
    for (int k = 1; k <= EXP_TERMS; k++) begin
      term = (term * 128'(i)) / (128'(k) << (SEG_SHIFT - 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // tanh(i/2^SEG_SHIFT) in Q40, using tanh(x) = (e^2x - 1) / (e^2x + 1).
  function automatic logic [127:0] tanh_q(input int i);
    logic [127:0] e;
    e = exp_q(i);
    return ((e - ONE_Q) << CALC_FRAC) / (e + ONE_Q);
  endfunction

  // Values are non-negative, so adding one half before truncation rounds
  // half away from zero.
  function automatic longint tanh_base(input int i, input int frac_bits);
    logic [127:0] r;
    r = ((tanh_q(i) << frac_bits) + HALF_Q) >> CALC_FRAC;
    return longint'(r);
  endfunction

  function automatic longint tanh_slope(input int i, input int frac_bits);
    logic [127:0] d;
    logic [127:0] r;
    d = tanh_q(i + 1) - tanh_q(i);
    r = ((d << (frac_bits + SEG_SHIFT)) + HALF_Q) >> CALC_FRAC;
    return longint'(r);
  endfunction

endpackage

// File: rtl/fixed_point_tanh_rom.sv
// Combinational segment lookup: seg -> (slope, base). Contents come from the
// package generator functions, so a different curve only swaps those functions.
module fixed_point_tanh_rom
  import cortez_tanh_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  seg_t             seg_i,
  output logic [WIDTH-1:0] slope_o,
  output logic [WIDTH-1:0] base_o
);

  logic [WIDTH-1:0] slope_tab [NUM_SEGMENTS];
  logic [WIDTH-1:0] base_tab  [NUM_SEGMENTS];

  generate
    for (genvar gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_tab
      localparam longint SLOPE_V = tanh_slope(gi, FRAC_BITS);
      localparam longint BASE_V  = tanh_base(gi, FRAC_BITS);
      assign slope_tab[gi] = SLOPE_V[WIDTH-1:0];
      assign base_tab[gi]  = BASE_V[WIDTH-1:0];
    end
  endgenerate

  assign slope_o = slope_tab[seg_i];
  assign base_o  = base_tab[seg_i];

endmodule

// File: rtl/fixed_point_tanh_core.sv
// Three-stage pipelined tanh(|x|): decode -> slope*offset -> base add/clamp.
// The original sign rides along untouched for the downstream restore stage.
module fixed_point_tanh_core
  import cortez_tanh_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] VALUE_IN,
  input  logic             SIGN_IN,
  input  logic             VALID_IN,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             TARGET_SIGN_OUT,
  output logic             VALID_OUT,
  output logic             RANGE_ERR_OUT
);

  localparam int                       OFF_BITS = FRAC_BITS - SEG_SHIFT;
  localparam logic [WIDTH-1:0]         ONE      = WIDTH'(1) << FRAC_BITS;
  localparam logic [WIDTH-1:0]         X_SAT_FX = WIDTH'(X_SAT_INT) << FRAC_BITS;
  localparam logic signed [WIDTH+1:0]  ONE_EXT  = (WIDTH+2)'(1) << FRAC_BITS;

  // ---------------- stage 1: decode ----------------
  logic             s1_valid_q;
  logic             s1_sign_q,  s1_sign_d;
  logic             s1_sat_q,   s1_sat_d;
  logic             s1_neg_q,   s1_neg_d;
  seg_t             s1_seg_q,   s1_seg_d;
  logic [WIDTH-1:0] s1_off_q,   s1_off_d;

  // Saturated inputs may carry an out-of-range segment index; its table entry
  // is discarded in stage 3, so only the low segment bits are kept.
  always_comb begin
    s1_sign_d = SIGN_IN;
    s1_neg_d  = VALUE_IN[WIDTH-1];
    s1_sat_d  = (VALUE_IN >= X_SAT_FX) || VALUE_IN[WIDTH-1];
    s1_seg_d  = VALUE_IN[OFF_BITS +: SEG_BITS];
    s1_off_d  = {{(WIDTH-OFF_BITS){1'b0}}, VALUE_IN[OFF_BITS-1:0]};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_seg_q   <= '0;
      s1_off_q   <= '0;
    end else begin
      s1_valid_q <= VALID_IN;
      if (VALID_IN) begin
        s1_sign_q <= s1_sign_d;
        s1_sat_q  <= s1_sat_d;
        s1_neg_q  <= s1_neg_d;
        s1_seg_q  <= s1_seg_d;
        s1_off_q  <= s1_off_d;
      end
    end
  end

  // ---------------- stage 2: table read and multiply ----------------
  logic [WIDTH-1:0]           rom_slope;
  logic [WIDTH-1:0]           rom_base;
  logic signed [2*WIDTH-1:0]  slope_ext;
  logic signed [2*WIDTH-1:0]  off_ext;
  logic signed [2*WIDTH-1:0]  prod;
  logic                       prod_unused;

  fixed_point_tanh_rom #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_rom (
    .seg_i   (s1_seg_q),
    .slope_o (rom_slope),
    .base_o  (rom_base)
  );

  assign slope_ext = {{WIDTH{rom_slope[WIDTH-1]}}, rom_slope};
  assign off_ext   = {{WIDTH{1'b0}}, s1_off_q};
  assign prod      = slope_ext * off_ext;

  // Dropping the low FRAC_BITS of the product is the arithmetic right shift
  // (floor); one guard bit above WIDTH keeps the sign of the shifted value.
  logic             s2_valid_q;
  logic             s2_sign_q, s2_sat_q, s2_neg_q;
  logic [WIDTH-1:0] s2_base_q, s2_base_d;
  logic [WIDTH:0]   s2_prod_q, s2_prod_d;

  assign s2_prod_d   = prod[FRAC_BITS +: WIDTH+1];
  assign s2_base_d   = rom_base;
  assign prod_unused = ^{prod[FRAC_BITS-1:0], prod[2*WIDTH-1:FRAC_BITS+WIDTH+1]};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_base_q  <= '0;
      s2_prod_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_sat_q  <= s1_sat_q;
        s2_neg_q  <= s1_neg_q;
        s2_base_q <= s2_base_d;
        s2_prod_q <= s2_prod_d;
      end
    end
  end

  // ---------------- stage 3: add, saturate, clamp ----------------
  logic signed [WIDTH+1:0] sum;
  logic                    sum_unused;
  logic [WIDTH-1:0]        value_q, value_d;
  logic                    sign_q, valid_q, err_q;

  assign sum        = $signed({{2{s2_base_q[WIDTH-1]}}, s2_base_q}) + $signed({s2_prod_q[WIDTH], s2_prod_q});
  assign sum_unused = ^sum[WIDTH+1:WIDTH];

  always_comb begin
    value_d = sum[WIDTH-1:0];
    if (s2_sat_q || (sum > ONE_EXT)) begin
      value_d = ONE;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= 1'b0;
      value_q <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        value_q <= value_d;
        sign_q  <= s2_sign_q;
        err_q   <= s2_neg_q;
      end
    end
  end

  assign VALUE_OUT       = value_q;
  assign TARGET_SIGN_OUT = sign_q;
  assign VALID_OUT       = valid_q;
  assign RANGE_ERR_OUT   = err_q;

endmodule

// File: tb/tb_fixed_point_tanh_core.sv
// Directed bench for fixed_point_tanh_core (WIDTH=16, FRAC_BITS=8): inputs are
// driven and outputs sampled on the falling edge, three cycles apart.
module tb_fixed_point_tanh_core;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [15:0] VALUE_IN;
  logic        SIGN_IN;
  logic        VALID_IN;
  logic [15:0] VALUE_OUT;
  logic        TARGET_SIGN_OUT;
  logic        VALID_OUT;
  logic        RANGE_ERR_OUT;

  int n_total = 0;
  int n_pass  = 0;

  int base_t  [8] = '{0, 118, 195, 232, 247, 253, 255, 256};
  int slope_t [8] = '{237, 153, 73, 30, 12, 4, 2, 1};

  fixed_point_tanh_core #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .VALUE_IN        (VALUE_IN),
    .SIGN_IN         (SIGN_IN),
    .VALID_IN        (VALID_IN),
    .VALUE_OUT       (VALUE_OUT),
    .TARGET_SIGN_OUT (TARGET_SIGN_OUT),
    .VALID_OUT       (VALID_OUT),
    .RANGE_ERR_OUT   (RANGE_ERR_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model(input logic [15:0] x);
    int seg;
    int off;
    int v;
    if (x[15] || x >= 16'h0400) return 16'h0100;
    seg = int'(x[9:7]);
    off = int'(x[6:0]);
    v = base_t[seg] + ((slope_t[seg] * off) >> 8);
    if (v > 256) v = 256;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [15:0] v, input logic s, input logic vld);
    @(negedge CLK);
    VALUE_IN = v;
    SIGN_IN  = s;
    VALID_IN = vld;
  endtask

  task automatic tick();
    drive(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [15:0] val,
                         input logic sgn, input logic err);
    chk({tag, ".valid"}, 32'(VALID_OUT), 32'(vld));
    chk({tag, ".value"}, 32'(VALUE_OUT), 32'(val));
    chk({tag, ".sign"},  32'(TARGET_SIGN_OUT), 32'(sgn));
    chk({tag, ".err"},   32'(RANGE_ERR_OUT), 32'(err));
  endtask

  logic        pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] dat [5];

  initial begin
    RSTN = 1'b0; VALUE_IN = '0; SIGN_IN = 1'b0; VALID_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk_out("in_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    RSTN = 1'b1;
    tick();
    chk_out("after_reset", 1'b0, 16'h0000, 1'b0, 1'b0);

    // single sample at 0.5, result after exactly three cycles for one cycle
    drive(16'h0080, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk_out("half", 1'b1, 16'h0076, 1'b1, 1'b0);
    tick();
    chk("half.pulse_end", 32'(VALID_OUT), 32'd0);

    // back-to-back: 0, 0.25, 1.0
    drive(16'h0000, 1'b0, 1'b1);
    drive(16'h0040, 1'b0, 1'b1);
    drive(16'h0100, 1'b1, 1'b1);
    tick();
    chk_out("zero", 1'b1, 16'd0, 1'b0, 1'b0);
    tick();
    chk_out("quarter", 1'b1, 16'd59, 1'b0, 1'b0);
    tick();
    chk_out("one", 1'b1, 16'd195, 1'b1, 1'b0);
    tick();
    chk("b2b.end", 32'(VALID_OUT), 32'd0);

    // saturation, top-of-range segment, and negative (range error)
    drive(16'h0400, 1'b0, 1'b1);
    drive(16'h7FFF, 1'b0, 1'b1);
    drive(16'h03FF, 1'b1, 1'b1);
    drive(16'h8000, 1'b1, 1'b1);
    chk_out("sat_4p0", 1'b1, 16'h0100, 1'b0, 1'b0);
    tick();
    chk_out("sat_max", 1'b1, 16'h0100, 1'b0, 1'b0);
    tick();
    chk_out("seg7_top", 1'b1, 16'd256, 1'b1, 1'b0);
    tick();
    chk_out("neg_err", 1'b1, 16'h0100, 1'b1, 1'b1);
    tick();
    chk("sat.end", 32'(VALID_OUT), 32'd0);

    // valid gaps preserved, random in-range data against the model
    for (int j = 0; j < 5; j++) dat[j] = 16'($urandom_range(0, 1023));
    for (int j = 0; j < 8; j++) begin
      if (j < 5) drive(dat[j], 1'(j % 2), pat[j]);
      else tick();
      if (j >= 3) begin
        chk("gap.valid", 32'(VALID_OUT), 32'(pat[j-3]));
        if (pat[j-3]) begin
          chk("gap.value", 32'(VALUE_OUT), 32'(model(dat[j-3])));
          chk("gap.sign", 32'(TARGET_SIGN_OUT), 32'((j - 3) % 2));
        end
      end
    end
    tick();
    chk("gap.tail", 32'(VALID_OUT), 32'd0);

    // asynchronous reset mid-cycle drops everything in flight
    drive(16'h0080, 1'b1, 1'b1);
    drive(16'h0100, 1'b1, 1'b1);
    drive(16'h0180, 1'b1, 1'b1);
    drive(16'h0200, 1'b1, 1'b1);
    chk_out("pre_rst", 1'b1, 16'h0076, 1'b1, 1'b0);
    #2;
    RSTN = 1'b0;
    VALID_IN = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dropped.valid", 32'(VALID_OUT), 32'd0);
    end
    drive(16'h0100, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk_out("post_rst", 1'b1, 16'd195, 1'b1, 1'b0);
    tick();
    chk("post_rst.end", 32'(VALID_OUT), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
